// File: rtl/mash_sdm_pkg.sv
// Shared types and constants for the MASH SDM sequencing controller.
package mash_sdm_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_RAMP  = 2'd3
  } state_t;

  localparam int unsigned FLUSH_CYCLES = 3;

  // Fibonacci LFSR for x^15 + x^14 + 1: feedback is the XOR of bits 14 and 13.
  localparam int unsigned LFSR_W    = 15;
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

endpackage

// File: rtl/mash_sdm_ramp.sv
// Combinational slew step: moves cur toward target by step, clamping at target.
module mash_sdm_ramp #(
  parameter int ACCUM_SIZE = 16,
  parameter int STEP_W     = 8
) (
  input  logic [ACCUM_SIZE-1:0] cur,
  input  logic [ACCUM_SIZE-1:0] target,
  input  logic [STEP_W-1:0]     step,
  output logic [ACCUM_SIZE-1:0] next_word,
  output logic                  arrive
);

  logic [ACCUM_SIZE:0]   diff_raw;
  logic [ACCUM_SIZE:0]   mag;
  logic [ACCUM_SIZE-1:0] step_ext;
  logic                  up;

  always_comb begin
    step_ext = {{(ACCUM_SIZE-STEP_W){1'b0}}, step};
    diff_raw = {1'b0, target} - {1'b0, cur};
    up       = ~diff_raw[ACCUM_SIZE];
    mag      = up ? diff_raw : ({(ACCUM_SIZE+1){1'b0}} - diff_raw);
    arrive   = (mag <= {1'b0, step_ext});
    // Arrival snaps to target, so a partial last step can never overshoot or wrap.
    if (arrive)
      next_word = target;
    else if (up)
      next_word = cur + step_ext;
    else
      next_word = cur - step_ext;
  end

endmodule

// File: rtl/mash_sdm_ctrl.sv
// Sequencing controller for the pipelined 1-1-1 MASH SDM: flush, run, slew-limited retune.
// Optional input dither on bit0 is enabled by defining MASH_SDM_CTRL_DITHER_EN.
module mash_sdm_ctrl
  import mash_sdm_pkg::*;
#(
  parameter int ACCUM_SIZE = 16,
  parameter int STEP_W     = 8,
  parameter int DWELL_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ACCUM_SIZE-1:0] cfg_target,
  input  logic [STEP_W-1:0]     cfg_step,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  output logic [ACCUM_SIZE-1:0] sdm_in,
  output logic                  sdm_rst_n,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [1:0]            flush_cnt;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic [DWELL_W-1:0]    dwell_q;
  logic [ACCUM_SIZE-1:0] cur;
  logic [ACCUM_SIZE-1:0] target_q;
  logic [STEP_W-1:0]     step_q;
  logic [ACCUM_SIZE-1:0] ramp_next;
  logic                  ramp_arrive;
  logic                  xfer;

  assign cfg_ready = (state == ST_OFF) || (state == ST_RUN);
  assign busy      = (state == ST_FLUSH) || (state == ST_RAMP);
  assign xfer      = cfg_valid && cfg_ready;

  mash_sdm_ramp #(
    .ACCUM_SIZE (ACCUM_SIZE),
    .STEP_W     (STEP_W)
  ) u_ramp (
    .cur       (cur),
    .target    (target_q),
    .step      (step_q),
    .next_word (ramp_next),
    .arrive    (ramp_arrive)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_OFF;
      flush_cnt <= '0;
      dwell_cnt <= '0;
      dwell_q   <= '0;
      cur       <= '0;
      target_q  <= '0;
      step_q    <= '0;
      sdm_rst_n <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer) begin
        target_q <= cfg_target;
        step_q   <= cfg_step;
        dwell_q  <= cfg_dwell;
      end
      // Enable low wins over every state; a coincident transfer still lands as a jump.
      if (!enable) begin
        state     <= ST_OFF;
        sdm_rst_n <= 1'b0;
        if (xfer) begin
          cur  <= cfg_target;
          done <= 1'b1;
        end
      end else begin
        case (state)
          ST_OFF: begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            if (xfer) begin
              cur  <= cfg_target;
              done <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt == 2'(FLUSH_CYCLES - 1)) begin
              state     <= ST_RUN;
              sdm_rst_n <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt + 2'd1;
            end
          end
          ST_RUN: begin
            if (xfer) begin
              if ((cfg_step == '0) || (cfg_target == cur)) begin
                cur  <= cfg_target;
                done <= 1'b1;
              end else begin
                state     <= ST_RAMP;
                dwell_cnt <= cfg_dwell;
              end
            end
          end
          ST_RAMP: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else begin
              cur <= ramp_next;
              if (ramp_arrive) begin
                state <= ST_RUN;
                done  <= 1'b1;
              end else begin
                dwell_cnt <= dwell_q;
              end
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

`ifdef MASH_SDM_CTRL_DITHER_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= LFSR_SEED;
    else if (sdm_rst_n)
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  assign sdm_in = {cur[ACCUM_SIZE-1:1], cur[0] ^ lfsr[0]};
`else
  assign sdm_in = cur;
`endif

endmodule

// File: tb/tb_mash_sdm_ctrl.sv
// Randomized self-checking bench for mash_sdm_ctrl against a closed-form ramp model.
module tb_mash_sdm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_target;
  logic [7:0]  cfg_step;
  logic [7:0]  cfg_dwell;
  logic [15:0] sdm_in;
  logic        sdm_rst_n;
  logic        busy;
  logic        done;

  mash_sdm_ctrl #(
    .ACCUM_SIZE (16),
    .STEP_W     (8),
    .DWELL_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_dwell  (cfg_dwell),
    .sdm_in     (sdm_in),
    .sdm_rst_n  (sdm_rst_n),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cur;
  logic        m_rstn;
  logic [14:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] dith(input logic [15:0] v);
`ifdef MASH_SDM_CTRL_DITHER_EN
    return v ^ {15'd0, m_lfsr[0]};
`else
    return v;
`endif
  endfunction

  // The LFSR model steps x^15+x^14+1 on each edge where the modulator was out of reset.
  task automatic tick();
    @(posedge clk);
    if (m_rstn) m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ev, input logic er,
                            input logic eb, input logic ed);
    m_rstn = er;
    chk({tag, ".sdm_in"},    32'(sdm_in),    32'(dith(ev)));
    chk({tag, ".sdm_rst_n"}, 32'(sdm_rst_n), 32'(er));
    chk({tag, ".busy"},      32'(busy),      32'(eb));
    chk({tag, ".done"},      32'(done),      32'(ed));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!eb));
  endtask

  task automatic go_enable();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs("flush", m_cur, (i == 3), (i < 3), 1'b0);
    end
  endtask

  task automatic off_jump(input logic [15:0] t);
    enable     = 1'b0;
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_step   = 8'($urandom_range(0, 255));
    cfg_dwell  = 8'($urandom_range(0, 3));
    chk("off_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    m_cur = t;
    check_outs("off_jump", t, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("off_idle", t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fall_with_xfer(input logic [15:0] t);
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_step   = 8'($urandom_range(1, 255));
    cfg_dwell  = 8'($urandom_range(0, 3));
    enable     = 1'b0;
    tick();
    cfg_valid = 1'b0;
    m_cur = t;
    check_outs("fall_xfer", t, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("fall_idle", t, 1'b0, 1'b0, 1'b0);
  endtask

  // Value after k steps of size s from start toward t, never passing t.
  function automatic logic [15:0] ramp_val(input int start, input int t, input int s, input int k);
    int v;
    if (t > start) begin
      v = start + k * s;
      if (v > t) v = t;
    end else begin
      v = start - k * s;
      if (v < t) v = t;
    end
    return 16'(v);
  endfunction

  // Transfer in RUN; abort_at>0 drops enable so the edge E0+abort_at sees it low.
  task automatic xfer_run(input logic [15:0] t, input int s, input int d, input int abort_at);
    int diff, kar, nend, start;
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_step   = 8'(s);
    cfg_dwell  = 8'(d);
    chk("run_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    if (s == 0 || t == m_cur) begin
      m_cur = t;
      check_outs("jump", t, 1'b1, 1'b0, 1'b1);
      tick();
      check_outs("jump_idle", t, 1'b1, 1'b0, 1'b0);
      return;
    end
    start = int'(m_cur);
    diff  = (int'(t) > start) ? int'(t) - start : start - int'(t);
    kar   = (diff + s - 1) / s;
    nend  = kar * (d + 1);
    for (int n = 0; n <= nend + 1; n++) begin
      if (n > 0) begin
        if (n == abort_at) begin
          enable = 1'b0;
          tick();
          m_cur = ramp_val(start, int'(t), s, (n - 1) / (d + 1));
          check_outs("abort", m_cur, 1'b0, 1'b0, 1'b0);
          tick();
          check_outs("abort_hold", m_cur, 1'b0, 1'b0, 1'b0);
          return;
        end
        tick();
      end
      check_outs("ramp", ramp_val(start, int'(t), s, n / (d + 1)), 1'b1, (n < nend), (n == nend));
    end
    m_cur = t;
  endtask

  task automatic reset_mid_ramp();
    cfg_valid  = 1'b1;
    cfg_target = m_cur ^ 16'h0100;
    cfg_step   = 8'd1;
    cfg_dwell  = 8'd0;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    m_cur  = '0;
    m_lfsr = 15'h0001;
    check_outs("rst_async", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic random_txn();
    int s, d, t, off;
    s = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
    d = int'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: t = int'($urandom_range(0, 65535));
      1: t = 0;
      2: t = 65535;
      default: begin
        off = int'($urandom_range(0, 8 * 255));
        t = ($urandom_range(0, 1) == 1) ? int'(m_cur) + off : int'(m_cur) - off;
      end
    endcase
    if (t < 0) t = 0;
    if (t > 65535) t = 65535;
    if (s != 0 && s < 128 && (t - int'(m_cur) > 2048 || int'(m_cur) - t > 2048)) s = s + 128;
    if ($urandom_range(0, 5) == 0 && s != 0)
      xfer_run(16'(t), s, d, int'($urandom_range(1, 6)));
    else
      xfer_run(16'(t), s, d, 0);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_target = '0;
    cfg_step   = '0;
    cfg_dwell  = '0;
    m_cur      = '0;
    m_rstn     = 1'b0;
    m_lfsr     = 15'h0001;
    #1;
    check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_outs("idle_off", 16'h0000, 1'b0, 1'b0, 1'b0);

    go_enable();
    xfer_run(16'h1000, 0, 0, 0);
    xfer_run(16'h1010, 4, 1, 0);
    xfer_run(16'h0010, 0, 0, 0);
    xfer_run(16'h0003, 5, 0, 0);
    xfer_run(16'hFFFF, 0, 0, 0);
    xfer_run(16'hFFFF, 7, 2, 0);
    xfer_run(16'h1000, 0, 0, 0);
    xfer_run(16'h1010, 4, 1, 5);
    off_jump(16'h1234);
    go_enable();
    fall_with_xfer(16'h4321);
    go_enable();
    xfer_run(16'h2000, 0, 0, 0);
    repeat (20) tick();
    check_outs("dc_hold", 16'h2000, 1'b1, 1'b0, 1'b0);
    reset_mid_ramp();
    go_enable();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          fall_with_xfer(16'($urandom_range(0, 65535)));
          go_enable();
        end
        1: begin
          reset_mid_ramp();
          go_enable();
        end
        2: begin
          enable = 1'b0;
          tick();
          check_outs("drop", m_cur, 1'b0, 1'b0, 1'b0);
          off_jump(16'($urandom_range(0, 65535)));
          go_enable();
        end
        default: begin
          random_txn();
          if (!enable) go_enable();
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mash_sdm_ctrl.md
# mash_sdm_ctrl

Sequencing controller for the pipelined 1-1-1 MASH SDM. It owns the modulator's input word and its reset. It accepts new target words over a valid/ready handshake and slew-limits the input word toward each target in programmable steps, so the modulator never sees a large instantaneous frequency jump. On enable it flushes the SDM pipeline before releasing it to run.

## Interface
- `ACCUM_SIZE`, 16: width of SDM input word and target.
- `STEP_W`, 8: width of ramp step size.
- `DWELL_W`, 8: width of dwell count between steps.

Ports (reset is asynchronous, active-high):
- `clk`  in  1  the only clock.
- `rst`  in  1  asynchronous active-high reset.
- `enable`  in  1  run request for the SDM.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  configuration can be accepted this cycle.
- `cfg_target`  in  ACCUM_SIZE  target input word.
- `cfg_step`  in  STEP_W  ramp step size; 0 means jump immediately.
- `cfg_dwell`  in  DWELL_W  extra cycles between steps; steps occur every dwell+1 cycles.
- `sdm_in`  out  ACCUM_SIZE  drives the SDM `in` port; registered.
- `sdm_rst_n`  out  1  drives the SDM's active-low reset; registered.
- `busy`  out  1  high in FLUSH or RAMP.
- `done`  out  1  one-cycle pulse when `sdm_in` reaches the target.

## Operation
- **States:** OFF, FLUSH, RUN, RAMP.
- **Reset values:** state OFF, `sdm_in`=0, `sdm_rst_n`=0, `busy`=0, `done`=0, internal word `cur`=0.
- **Handshake:** `cfg_ready` = (state==OFF or RUN), decoded from state. A transfer occurs on an edge where `cfg_valid`&&`cfg_ready`. The target, step and dwell are latched on that edge.
- **OFF:** `sdm_rst_n`=0.
  - A transfer sets `cur`=target directly (jump), pulses `done`, and stays OFF.
  - `enable`=1 moves to FLUSH.
- **FLUSH:** `sdm_rst_n`=0 for exactly 3 cycles, which empties the SDM carry-delay and out registers. Then RUN with `sdm_rst_n`=1.
- **RUN:** `sdm_rst_n`=1.
  - A transfer with step==0 or target==`cur` jumps: `cur`=target, `done` pulses, and the state stays RUN.
  - Any other transfer moves to RAMP with the dwell counter loaded with `cfg_dwell`.
- **RAMP:** on each edge:
  - If counter≠0, decrement it.
  - Otherwise, if |target−`cur`| ≤ step: `cur`=target, go to RUN, pulse `done`.
  - Otherwise: `cur`=`cur`±step toward the target, and reload counter=dwell.
- **Arithmetic:** unsigned. The difference is computed in ACCUM_SIZE+1 bits. `cur` never overshoots and never wraps.
- **`enable` low:** in any state, `enable`=0 goes to OFF on the next edge.
  - An in-progress ramp is aborted and `cur` holds its intermediate value; no `done` pulse.
  - FLUSH restarts from count 0 on the next enable.
- **Simultaneous transfer and `enable` fall in RUN:** the transfer is treated as a jump (`cur`=target, `done` pulses) and the state goes to OFF.
- **`rst` mid-operation:** all outputs return to their reset values immediately; any pending target is discarded.

## Timing
- If a transfer happens at edge E0 in RUN with step>0, steps occur at edges E0+(k)(dwell+1), k≥1. `done` is high for the cycle following the final step edge.
- A jump transfer at E0 gives `sdm_in`=target and `done`=1 during the cycle after E0.
- `enable` rising at E0 gives `sdm_rst_n`=1 from E0+4 (FLUSH spans E0+1..E0+3).
- `busy` is decoded from the state register, so it has no extra latency.

## Configuration
- Macro `MASH_SDM_CTRL_DITHER_EN`.
  - **Defined:** a 15-bit LFSR (x^15+x^14+1, seed 1) advances every cycle in which `sdm_rst_n`=1, and resets to the seed on `rst`. Output `sdm_in` = `cur` with bit0 XORed with LFSR bit0. This breaks idle tones for DC inputs.
  - **Not defined:** `sdm_in` = `cur` exactly; no LFSR logic is present.

## Structure
- **Package `mash_sdm_pkg`:**
  - state enum (OFF, FLUSH, RUN, RAMP);
  - `FLUSH_CYCLES`=3;
  - LFSR seed and taps constants.
- **Sub-module `mash_sdm_ramp`:** combinational step/clamp unit. It takes `cur`, target and step, and returns the next word plus an `arrive` flag. The FSM, dwell counter and LFSR stay in the top level.

## Test plan
- Reset then enable=1: `sdm_rst_n` stays 0 for 3 cycles after the enable edge, then goes to 1; `sdm_in`=0; `busy` is high exactly during FLUSH.
- In RUN with `cur`=0x1000, load target 0x1010, step 4, dwell 1: `sdm_in` takes 0x1004, 0x1008, 0x100C, 0x1010 at E0+2/+4/+6/+8; `done` is a single pulse after E0+8; `cfg_ready` is 0 throughout RAMP.
- Downward ramp from 0x0010 to 0x0003 with step 5, dwell 0: `sdm_in` takes 0x000B, then 0x0006, then clamps to 0x0003 with no underflow.
- Step=0 with target 0xFFFF in RUN: `sdm_in` becomes 0xFFFF the next cycle, `done` pulses, and the state stays RUN.
- Drop `enable` mid-ramp at 0x1008: the state goes to OFF, `sdm_rst_n` goes to 0, `sdm_in` holds 0x1008, and there is no `done`. Asserting `rst` mid-ramp returns all outputs to their reset values asynchronously.
- With `MASH_SDM_CTRL_DITHER_EN` defined and `cur`=0x2000 in RUN: `sdm_in`[15:1] stays constant and bit0 follows the LFSR sequence from seed 1.
